// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared constants for the load/store unit: RV opcodes, funct3 encodings,
// FSM state encoding and the funct3 decode helper.
package lsu_mem_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  // size is log2 of the access width in bytes
  typedef struct packed {
    logic       legal;
    logic [1:0] size;
    logic       sign;
  } dec_t;

  // funct3[1:0] is log2(bytes) and funct3[2] marks the unsigned loads.
  function automatic dec_t decode_funct3(input logic is_load, input logic [2:0] f3,
                                         input logic wide);
    dec_t d;
    d.legal = 1'b1;
    d.size  = f3[1:0];
    d.sign  = is_load && !f3[2];
    if (f3 == 3'd7 || (!is_load && f3[2])) d.legal = 1'b0;
    if (f3[1:0] == 2'd3 || f3 == F3_LWU) d.legal = d.legal && wide;
    return d;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: byte strobes over a two-beat window, store-data
// replication/shift, and load-data extraction with sign/zero extension.
module lsu_lane_align #(
  parameter  int BUS_W = 32,
  localparam int NB    = BUS_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]         size_i,
  input  logic [OFF_W-1:0]   off_i,
  input  logic               sign_i,
  input  logic [BUS_W-1:0]   wdata_i,
  input  logic [BUS_W-1:0]   rdata0_i,
  input  logic [BUS_W-1:0]   rdata1_i,
  output logic [2*NB-1:0]    strobe_o,
  output logic [2*BUS_W-1:0] wdata_o,
  output logic [BUS_W-1:0]   rdata_o
);

  logic [2*NB-1:0]  size_mask;
  logic [BUS_W-1:0] rd_raw;
  logic [BUS_W-1:0] val_mask;
  logic             sign_bit;

  always_comb begin
    size_mask = '0;
    case (size_i)
      2'd0:    size_mask = (2*NB)'(8'h01);
      2'd1:    size_mask = (2*NB)'(8'h03);
      2'd2:    size_mask = (2*NB)'(8'h0F);
      default: size_mask = (2*NB)'(8'hFF);
    endcase
    strobe_o = size_mask << off_i;
  end

  assign wdata_o = {wdata_i, wdata_i} << {off_i, 3'b000};

  // Shifting the concatenated beats equals (beat0 >> 8*off) | (beat1 << 8*(NB-off)).
  assign rd_raw = BUS_W'({rdata1_i, rdata0_i} >> {off_i, 3'b000});

  always_comb begin
    val_mask = '1;
    sign_bit = rd_raw[BUS_W-1];
    case (size_i)
      2'd0: begin
        val_mask = BUS_W'(8'hFF);
        sign_bit = rd_raw[7];
      end
      2'd1: begin
        val_mask = BUS_W'(16'hFFFF);
        sign_bit = rd_raw[15];
      end
      2'd2: begin
        val_mask = BUS_W'(32'hFFFF_FFFF);
        sign_bit = rd_raw[31];
      end
      default: begin
        val_mask = '1;
        sign_bit = rd_raw[BUS_W-1];
      end
    endcase
    rdata_o = (rd_raw & val_mask) | ((sign_i && sign_bit) ? ~val_mask : '0);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one access from execute, runs one or two aligned
// req/gnt(/rvalid) bus beats and returns a single-cycle response.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int BUS_W          = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_instr_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [BUS_W-1:0]     req_wdata_i,
  output logic                 resp_valid_o,
  output logic [BUS_W-1:0]     resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_wen_o,
  output logic                 mem_ren_o,
  output logic [BUS_W/8-1:0]   mem_wstrobe_o,
  output logic [BUS_W-1:0]     mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [BUS_W-1:0]     mem_rdata_i
);

  localparam int NB    = BUS_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic              sign_q;
  logic              load_q;
  logic              split_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [NB-1:0]     strobe1_q;
  logic [BUS_W-1:0]  wdata1_q;
  logic [BUS_W-1:0]  rdata0_q;

  logic              resp_valid_q;
  logic [BUS_W-1:0]  resp_rdata_q;
  logic              resp_err_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic              mem_ren_q;
  logic [NB-1:0]     mem_strobe_q;
  logic [BUS_W-1:0]  mem_wdata_q;

  logic              is_load;
  logic              is_store;
  dec_t              dec;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_base;
  logic              in_idle;
  logic              need_hi;
  logic              unused_instr;

  logic [1:0]         al_size;
  logic [OFF_W-1:0]   al_off;
  logic               al_sign;
  logic [BUS_W-1:0]   al_rdata0;
  logic [BUS_W-1:0]   al_rdata1;
  logic [2*NB-1:0]    al_strobe;
  logic [2*BUS_W-1:0] al_wdata;
  logic [BUS_W-1:0]   al_rdata;

  assign is_load      = req_instr_i[6:0] == OPC_LOAD;
  assign is_store     = req_instr_i[6:0] == OPC_STORE;
  assign dec          = decode_funct3(is_load, req_instr_i[14:12], BUS_W == 64);
  assign req_off      = req_addr_i[OFF_W-1:0];
  assign req_base     = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_instr = ^{req_instr_i[31:15], req_instr_i[11:7]};

  // The aligner sees the incoming request while idle and the latched access otherwise.
  assign in_idle   = state_q == ST_IDLE;
  assign al_size   = in_idle ? dec.size : size_q;
  assign al_off    = in_idle ? req_off : off_q;
  assign al_sign   = in_idle ? dec.sign : sign_q;
  assign al_rdata0 = (state_q == ST_WAIT0) ? mem_rdata_i : rdata0_q;
  assign al_rdata1 = (state_q == ST_WAIT1) ? mem_rdata_i : '0;
  assign need_hi   = |al_strobe[2*NB-1:NB];

  lsu_lane_align #(
    .BUS_W (BUS_W)
  ) u_align (
    .size_i   (al_size),
    .off_i    (al_off),
    .sign_i   (al_sign),
    .wdata_i  (req_wdata_i),
    .rdata0_i (al_rdata0),
    .rdata1_i (al_rdata1),
    .strobe_o (al_strobe),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      size_q       <= '0;
      off_q        <= '0;
      sign_q       <= 1'b0;
      load_q       <= 1'b0;
      split_q      <= 1'b0;
      addr1_q      <= '0;
      strobe1_q    <= '0;
      wdata1_q     <= '0;
      rdata0_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_strobe_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            size_q    <= dec.size;
            off_q     <= req_off;
            sign_q    <= dec.sign;
            load_q    <= is_load;
            split_q   <= need_hi;
            addr1_q   <= req_base + ADDR_W'(NB);
            strobe1_q <= al_strobe[2*NB-1:NB];
            wdata1_q  <= is_store ? al_wdata[2*BUS_W-1:BUS_W] : '0;
            if (!(is_load || is_store)) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else if (!dec.legal || (need_hi && !MISALIGN_SPLIT)) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q      <= ST_ISSUE0;
              mem_req_q    <= 1'b1;
              mem_addr_q   <= req_base;
              mem_wen_q    <= is_store;
              mem_ren_q    <= is_load;
              mem_strobe_q <= al_strobe[NB-1:0];
              mem_wdata_q  <= is_store ? al_wdata[BUS_W-1:0] : '0;
            end
          end
        end
        ST_ISSUE0: begin
          if (mem_gnt_i) begin
            if (load_q) begin
              state_q   <= ST_WAIT0;
              mem_req_q <= 1'b0;
              mem_ren_q <= 1'b0;
            end else if (split_q) begin
              state_q      <= ST_ISSUE1;
              mem_addr_q   <= addr1_q;
              mem_strobe_q <= strobe1_q;
              mem_wdata_q  <= wdata1_q;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              mem_req_q    <= 1'b0;
              mem_wen_q    <= 1'b0;
            end
          end
        end
        ST_WAIT0: begin
          if (mem_rvalid_i) begin
            if (split_q) begin
              state_q      <= ST_ISSUE1;
              rdata0_q     <= mem_rdata_i;
              mem_req_q    <= 1'b1;
              mem_ren_q    <= 1'b1;
              mem_addr_q   <= addr1_q;
              mem_strobe_q <= strobe1_q;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= al_rdata;
            end
          end
        end
        ST_ISSUE1: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            if (load_q) begin
              state_q <= ST_WAIT1;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT1: begin
          if (mem_rvalid_i) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= al_rdata;
          end
        end
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = in_idle;
  assign resp_valid_o  = resp_valid_q;
  assign resp_rdata_o  = resp_rdata_q;
  assign resp_err_o    = resp_err_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wen_o     = mem_wen_q;
  assign mem_ren_o     = mem_ren_q;
  assign mem_wstrobe_o = mem_strobe_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: three instances (32-bit split, 32-bit trap,
// 64-bit split) share stimulus; a selector routes handshakes and outputs.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_instr = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  int          sel = 0;
  int          cyc = 0;
  int          reqCnt = 0;
  int          respCnt = 0;
  int          checkCount = 0;
  int          errorCount = 0;

  logic        a_ready, a_rvalid, a_err, a_req, a_wen, a_ren;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_strb;
  logic        b_ready, b_rvalid, b_err, b_req, b_wen, b_ren;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_strb;
  logic        c_ready, c_rvalid, c_err, c_req, c_wen, c_ren;
  logic [63:0] c_rdata, c_wdata;
  logic [31:0] c_addr;
  logic [7:0]  c_strb;

  logic        o_ready, o_rvalid, o_err, o_req, o_wen, o_ren;
  logic [63:0] o_rdata, o_wdata, o_addr, o_strb;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.BUS_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 0), .req_ready_o(a_ready),
    .req_instr_i(req_instr), .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]),
    .resp_valid_o(a_rvalid), .resp_rdata_o(a_rdata), .resp_err_o(a_err),
    .mem_req_o(a_req), .mem_gnt_i(mem_gnt && sel == 0), .mem_addr_o(a_addr),
    .mem_wen_o(a_wen), .mem_ren_o(a_ren), .mem_wstrobe_o(a_strb), .mem_wdata_o(a_wdata),
    .mem_rvalid_i(mem_rvalid && sel == 0), .mem_rdata_i(mem_rdata[31:0]));

  lsu_mem_ctrl #(.BUS_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 1), .req_ready_o(b_ready),
    .req_instr_i(req_instr), .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]),
    .resp_valid_o(b_rvalid), .resp_rdata_o(b_rdata), .resp_err_o(b_err),
    .mem_req_o(b_req), .mem_gnt_i(mem_gnt && sel == 1), .mem_addr_o(b_addr),
    .mem_wen_o(b_wen), .mem_ren_o(b_ren), .mem_wstrobe_o(b_strb), .mem_wdata_o(b_wdata),
    .mem_rvalid_i(mem_rvalid && sel == 1), .mem_rdata_i(mem_rdata[31:0]));

  lsu_mem_ctrl #(.BUS_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dutC (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 2), .req_ready_o(c_ready),
    .req_instr_i(req_instr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(c_rvalid), .resp_rdata_o(c_rdata), .resp_err_o(c_err),
    .mem_req_o(c_req), .mem_gnt_i(mem_gnt && sel == 2), .mem_addr_o(c_addr),
    .mem_wen_o(c_wen), .mem_ren_o(c_ren), .mem_wstrobe_o(c_strb), .mem_wdata_o(c_wdata),
    .mem_rvalid_i(mem_rvalid && sel == 2), .mem_rdata_i(mem_rdata));

  always_comb begin
    o_ready = a_ready; o_rvalid = a_rvalid; o_err = a_err; o_req = a_req;
    o_wen = a_wen; o_ren = a_ren; o_rdata = 64'(a_rdata); o_wdata = 64'(a_wdata);
    o_addr = 64'(a_addr); o_strb = 64'(a_strb);
    if (sel == 1) begin
      o_ready = b_ready; o_rvalid = b_rvalid; o_err = b_err; o_req = b_req;
      o_wen = b_wen; o_ren = b_ren; o_rdata = 64'(b_rdata); o_wdata = 64'(b_wdata);
      o_addr = 64'(b_addr); o_strb = 64'(b_strb);
    end else if (sel == 2) begin
      o_ready = c_ready; o_rvalid = c_rvalid; o_err = c_err; o_req = c_req;
      o_wen = c_wen; o_ren = c_ren; o_rdata = c_rdata; o_wdata = c_wdata;
      o_addr = 64'(c_addr); o_strb = 64'(c_strb);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_req) reqCnt <= reqCnt + 1;
    if (o_rvalid) respCnt <= respCnt + 1;
  end

  function automatic logic [31:0] mkInstr(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One access end to end; the bench plays the memory and checks every beat and the response.
  task automatic applyStimulus(input string tag, input int dut, input logic [31:0] instr,
      input logic [31:0] addr, input logic [63:0] wdata, input int nBeats, input int gntWait,
      input logic [63:0] a0, input logic [63:0] s0, input logic [63:0] w0, input logic [63:0] r0,
      input logic [63:0] a1, input logic [63:0] s1, input logic [63:0] w1, input logic [63:0] r1,
      input logic [63:0] eRdata, input logic eErr, input int eLat);
    logic [63:0] ea [2];
    logic [63:0] es [2];
    logic [63:0] ew [2];
    logic [63:0] er [2];
    logic        isLoad;
    int          t0, waited, reqSnap;
    ea[0] = a0; ea[1] = a1; es[0] = s0; es[1] = s1;
    ew[0] = w0; ew[1] = w1; er[0] = r0; er[1] = r1;
    isLoad = instr[6:0] == OPC_LOAD;
    sel = dut;
    @(negedge clk);
    checkOutput($sformatf("%s ready", tag), 64'(o_ready), 64'd1);
    reqSnap = reqCnt;
    t0 = cyc;
    req_valid = 1'b1; req_instr = instr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < nBeats; b++) begin
      waited = 0;
      while (!o_req && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput($sformatf("%s b%0d req", tag, b), 64'(o_req), 64'd1);
      checkOutput($sformatf("%s b%0d busy", tag, b), 64'(o_ready), 64'd0);
      checkOutput($sformatf("%s b%0d addr", tag, b), o_addr, ea[b]);
      checkOutput($sformatf("%s b%0d strobe", tag, b), o_strb, es[b]);
      checkOutput($sformatf("%s b%0d dir", tag, b), {62'd0, o_wen, o_ren}, {62'd0, !isLoad, isLoad});
      if (!isLoad) checkOutput($sformatf("%s b%0d wdata", tag, b), o_wdata, ew[b]);
      repeat (gntWait) @(negedge clk);
      checkOutput($sformatf("%s b%0d hold", tag, b), {o_req, o_addr}, {1'b1, ea[b]});
      mem_gnt = 1'b1;
      if (isLoad) begin
        mem_rvalid = 1'b1;
        mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      end
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (isLoad) begin
        mem_rvalid = 1'b1;
        mem_rdata = er[b];
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata = '0;
      end
    end
    waited = 0;
    while (!o_rvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput($sformatf("%s resp", tag), 64'(o_rvalid), 64'd1);
    checkOutput($sformatf("%s rdata", tag), o_rdata, eRdata);
    checkOutput($sformatf("%s err", tag), 64'(o_err), 64'(eErr));
    if (eLat >= 0) checkOutput($sformatf("%s latency", tag), 64'(cyc - t0), 64'(eLat));
    if (nBeats == 0) checkOutput($sformatf("%s nobus", tag), 64'(reqCnt - reqSnap), 64'd0);
    @(negedge clk);
    checkOutput($sformatf("%s pulse", tag), 64'(o_rvalid), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ready"}, 64'(o_ready), 64'd1);
    checkOutput({tag, " resp"}, {61'd0, o_rvalid, o_err, 1'b0}, 64'd0);
    checkOutput({tag, " rdata"}, o_rdata, 64'd0);
    checkOutput({tag, " bus"}, {61'd0, o_req, o_wen, o_ren}, 64'd0);
    checkOutput({tag, " addr"}, o_addr, 64'd0);
    checkOutput({tag, " strobe"}, o_strb, 64'd0);
    checkOutput({tag, " wdata"}, o_wdata, 64'd0);
  endtask

  initial begin
    int respSnap, waited;
    repeat (2) @(negedge clk);
    sel = 0;
    checkResetOutputs("rstA");
    sel = 2;
    checkResetOutputs("rstC");
    rst_n = 1'b1;
    @(negedge clk);

    // 32-bit bus, misaligned accesses split
    applyStimulus("SW", 0, mkInstr(OPC_STORE, F3_SW), 32'h100, 64'hDEADBEEF, 1, 0,
                  64'h100, 64'hF, 64'hDEADBEEF, 0, 0, 0, 0, 0, 64'd0, 1'b0, 2);
    applyStimulus("SB", 0, mkInstr(OPC_STORE, F3_SB), 32'h103, 64'hAB, 1, 2,
                  64'h100, 64'h8, 64'hAB000000, 0, 0, 0, 0, 0, 64'd0, 1'b0, 4);
    applyStimulus("LB", 0, mkInstr(OPC_LOAD, F3_LB), 32'h102, 64'd0, 1, 0,
                  64'h100, 64'h4, 0, 64'h00800000, 0, 0, 0, 0, 64'hFFFFFF80, 1'b0, 3);
    applyStimulus("LBU", 0, mkInstr(OPC_LOAD, F3_LBU), 32'h102, 64'd0, 1, 1,
                  64'h100, 64'h4, 0, 64'h00800000, 0, 0, 0, 0, 64'h00000080, 1'b0, -1);
    applyStimulus("LWsplit", 0, mkInstr(OPC_LOAD, F3_LW), 32'h0FE, 64'd0, 2, 0,
                  64'h0FC, 64'hC, 0, 64'h33445566, 64'h100, 64'h3, 0, 64'h77881122,
                  64'h11223344, 1'b0, 5);
    applyStimulus("SWsplit", 0, mkInstr(OPC_STORE, F3_SW), 32'h101, 64'hAABBCCDD, 2, 0,
                  64'h100, 64'hE, 64'hBBCCDD00, 0, 64'h104, 64'h1, 64'hBBCCDDAA, 0,
                  64'd0, 1'b0, 3);
    applyStimulus("LHsplit", 0, mkInstr(OPC_LOAD, F3_LH), 32'h0FF, 64'd0, 2, 1,
                  64'h0FC, 64'h8, 0, 64'h12000000, 64'h100, 64'h1, 0, 64'h000000F1,
                  64'hFFFFF112, 1'b0, -1);
    applyStimulus("SHwrap", 0, mkInstr(OPC_STORE, F3_SH), 32'hFFFFFFFF, 64'h1234, 2, 0,
                  64'hFFFFFFFC, 64'h8, 64'h34000000, 0, 64'h0, 64'h1, 64'h34000012, 0,
                  64'd0, 1'b0, -1);
    applyStimulus("LD32", 0, mkInstr(OPC_LOAD, F3_LD), 32'h100, 64'd0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1'b1, 1);
    applyStimulus("LWU32", 0, mkInstr(OPC_LOAD, F3_LWU), 32'h100, 64'd0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1'b1, 1);
    applyStimulus("ALUop", 0, mkInstr(7'h33, 3'd0), 32'h100, 64'd0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1'b0, 1);

    // 32-bit bus, misaligned accesses trapped
    applyStimulus("LWtrap", 1, mkInstr(OPC_LOAD, F3_LW), 32'h0FE, 64'd0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1'b1, 1);
    applyStimulus("LHUtrapcfg", 1, mkInstr(OPC_LOAD, F3_LHU), 32'h102, 64'd0, 1, 0,
                  64'h100, 64'hC, 0, 64'h89AB0000, 0, 0, 0, 0, 64'h000089AB, 1'b0, 3);

    // 64-bit bus
    applyStimulus("SD64", 2, mkInstr(OPC_STORE, F3_SD), 32'h8, 64'h0123456789ABCDEF, 1, 0,
                  64'h8, 64'hFF, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 64'd0, 1'b0, 2);
    applyStimulus("LW64", 2, mkInstr(OPC_LOAD, F3_LW), 32'hC, 64'd0, 1, 0,
                  64'h8, 64'hF0, 0, 64'h8765432100000000, 0, 0, 0, 0,
                  64'hFFFFFFFF87654321, 1'b0, 3);
    applyStimulus("LWU64", 2, mkInstr(OPC_LOAD, F3_LWU), 32'hC, 64'd0, 1, 0,
                  64'h8, 64'hF0, 0, 64'h8765432100000000, 0, 0, 0, 0,
                  64'h0000000087654321, 1'b0, 3);

    // Reset while a load waits for rvalid
    sel = 0;
    @(negedge clk);
    req_valid = 1'b1; req_instr = mkInstr(OPC_LOAD, F3_LW); req_addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!o_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midrst req", 64'(o_req), 64'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    respSnap = respCnt;
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst noresp", 64'(respCnt - respSnap), 64'd0);
    checkOutput("midrst idle", {62'd0, o_ready, o_req}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
